alu_cmd_dispatcher: RTL

- Upstream feeder for the 4-operation 8-bit ALU.
- Buffers operand/opcode commands from a valid/ready source in a FIFO and issues them one at a time to the ALU's start/a/b/op interface.
- Waits for the ALU's done pulse, then presents the 16-bit result, with its opcode and a user tag, on a valid/ready output.
- Exactly one command is in flight in the ALU at any time.

---
 rtl/alu_cmd_dispatcher.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_dispatcher.sv
// alu_cmd_dispatcher: buffers ALU commands in a small FIFO, issues them one at
// a time to a start/done ALU and presents each result on a valid/ready output.
// Optional build macro: ALU_TIMEOUT_EN adds a WAIT-state watchdog that reports
// a timed-out command with out_err=1 and a zero result.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until that edge; the
// input side accepts only when not full (no push-through from a same-cycle pop).
module alu_cmd_dispatcher #(
  parameter int DEPTH          = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_a,
  input  logic [7:0]                 in_b,
  input  logic [1:0]                 in_op,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       alu_start,
  output logic [7:0]                 alu_a,
  output logic [7:0]                 alu_b,
  output logic [1:0]                 alu_op,
  input  logic                       alu_done,
  input  logic [15:0]                alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_result,
  output logic [1:0]                 out_op,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 8 + 8 + 2 + TAG_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_e;

  state_e             state_q, state_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               fifo_full, push, pop, finish_wait;
  logic [7:0]         alu_a_q, alu_b_q;
  logic [1:0]         alu_op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [15:0]        out_result_q;
  logic [1:0]         out_op_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic               timeout;

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  // Every entry into ISSUE consumes the FIFO head.
  assign pop        = (state_d == S_ISSUE);
  assign finish_wait = (state_q == S_WAIT) && (alu_done || timeout);

  assign alu_start  = (state_q == S_ISSUE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_valid  = (state_q == S_OUTPUT);
  assign out_result = out_result_q;
  assign out_op     = out_op_q;
  assign out_tag    = out_tag_q;
  assign fifo_count = count_q;

  // FIFO storage; data needs no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b, in_op, in_tag};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: one command in flight; OUTPUT may chain straight to ISSUE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (count_q != '0) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   if (alu_done || timeout) state_d = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_d = (count_q != '0) ? S_ISSUE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Issue registers: loaded on pop and held until the next issue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      tag_q    <= '0;
    end else if (pop) begin
      {alu_a_q, alu_b_q, alu_op_q, tag_q} <= mem_q[rd_ptr_q];
    end
  end

  // Result capture at the end of WAIT; a timeout reports a zero result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_result_q <= '0;
      out_op_q     <= '0;
      out_tag_q    <= '0;
    end else if (finish_wait) begin
      out_result_q <= alu_done ? alu_result : 16'h0000;
      out_op_q     <= alu_op_q;
      out_tag_q    <= tag_q;
    end
  end

`ifdef ALU_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q;
  logic            out_err_q;

  assign timeout = (state_q == S_WAIT) && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign out_err = out_err_q;

  // Watchdog counts cycles spent in WAIT; idles at zero elsewhere.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                wdog_q <= '0;
    else if (state_q != S_WAIT)  wdog_q <= '0;
    else                         wdog_q <= wdog_q + WD_W'(1);
  end

  // Error flag: set when WAIT ends without done, cleared on the output handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                               out_err_q <= 1'b0;
    else if (finish_wait)                       out_err_q <= !alu_done;
    else if (state_q == S_OUTPUT && out_ready)  out_err_q <= 1'b0;
  end
`else
  assign timeout = 1'b0;
  assign out_err = 1'b0;
`endif

endmodule
